// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the board SRAM arbiter.
package sram_arb_pkg;

   localparam int unsigned SRAM_AW = 20;
   localparam int unsigned SRAM_DW = 16;

   typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} sram_arb_state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_RD, SRC_WR0, SRC_WR1} sram_src_t;

   // One writer's request payload.
   typedef struct packed {
      logic [SRAM_AW-1:0] addr;
      logic [SRAM_DW-1:0] data;
   } sram_wr_t;

endpackage

// File: rtl/sram_arb_select.sv
// Combinational requester picker: read priority bounded by burst saturation,
// writers served round-robin from rr_ptr.
module sram_arb_select
   import sram_arb_pkg::*;
(
   input  logic       rd_req,
   input  logic [1:0] wr_req,
   input  logic       rr_ptr,
   input  logic       rd_sat,
   output sram_src_t  src_c
);

   always_comb begin
      src_c = SRC_NONE;
      if (rd_req && (!(|wr_req) || !rd_sat)) begin
         src_c = SRC_RD;
      end else if (wr_req[rr_ptr]) begin
         src_c = rr_ptr ? SRC_WR1 : SRC_WR0;
      end else if (wr_req[!rr_ptr]) begin
         src_c = rr_ptr ? SRC_WR0 : SRC_WR1;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM sequencer shared by the VGA reader and two writers.
// Owns all SRAM strobes, the address bus and the DQ tri-state driver.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned MAX_RD_BURST  = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               rd_req,
   input  logic [SRAM_AW-1:0] rd_addr,
   output logic               rd_gnt,
   output logic               rd_valid,
   output logic [SRAM_DW-1:0] rd_data,
   input  logic [1:0]         wr_req,
   input  logic [SRAM_AW-1:0] wr_addr0,
   input  logic [SRAM_AW-1:0] wr_addr1,
   input  logic [SRAM_DW-1:0] wr_data0,
   input  logic [SRAM_DW-1:0] wr_data1,
   output logic [1:0]         wr_ack,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_WE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

   localparam int unsigned CNT_W   = $clog2(ACCESS_CYCLES);
   localparam int unsigned BURST_W = $clog2(MAX_RD_BURST + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_RD_BURST);

   sram_arb_state_t    state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rr_ptr_q, rr_ptr_d;
   logic [BURST_W-1:0] rd_burst_q, rd_burst_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [SRAM_DW-1:0] wdata_q, wdata_d;
   logic [SRAM_DW-1:0] rd_data_q, rd_data_d;
   logic               rd_gnt_q, rd_gnt_d;
   logic               rd_valid_q, rd_valid_d;
   logic [1:0]         wr_ack_q, wr_ack_d;
   logic               ce_n_q, ce_n_d;
   logic               oe_n_q, oe_n_d;
   logic               we_n_q, we_n_d;
   logic               bl_n_q, bl_n_d;
   logic               dq_oe_q, dq_oe_d;

   sram_src_t src_c;
   sram_wr_t  wr_sel_c;
   logic      rd_sat_c, wr_pend_c, in_acc_c, last_c, gnt_rd_c, gnt_wr_c;

   assign rd_sat_c  = (rd_burst_q >= BURST_MAX);
   assign wr_pend_c = |wr_req;

   sram_arb_select u_select (
      .rd_req (rd_req),
      .wr_req (wr_req),
      .rr_ptr (rr_ptr_q),
      .rd_sat (rd_sat_c),
      .src_c  (src_c)
   );

   // Next-state, capture and registered-strobe computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      rr_ptr_d   = rr_ptr_q;
      rd_burst_d = rd_burst_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_data_d  = rd_data_q;
      rd_gnt_d   = 1'b0;
      rd_valid_d = 1'b0;
      wr_ack_d   = 2'b00;
      gnt_rd_c   = 1'b0;
      gnt_wr_c   = 1'b0;
      wr_sel_c   = (src_c == SRC_WR1) ? '{addr: wr_addr1, data: wr_data1}
                                      : '{addr: wr_addr0, data: wr_data0};
      in_acc_c   = (state_q == READ) || (state_q == WRITE);
      last_c     = (cnt_q == CNT_LAST);

      if (in_acc_c && !last_c) cnt_d = CNT_W'(cnt_q + 1'b1);

      if (state_q == READ && last_c) begin
         rd_valid_d = 1'b1;
         rd_data_d  = SRAM_DQ;
      end

      if (state_q == IDLE || (in_acc_c && last_c)) begin
         case (src_c)
            SRC_RD: begin
               // A read straight after a write waits one bus-turnaround cycle.
               if (state_q == WRITE) state_d = TURN;
               else                  gnt_rd_c = 1'b1;
            end
            SRC_WR0, SRC_WR1: gnt_wr_c = 1'b1;
            default:          state_d  = IDLE;
         endcase
      end else if (state_q == TURN) begin
         gnt_rd_c = 1'b1;
      end

      if (gnt_rd_c) begin
         state_d  = READ;
         addr_d   = rd_addr;
         rd_gnt_d = 1'b1;
         if (wr_pend_c && !rd_sat_c) rd_burst_d = BURST_W'(rd_burst_q + 1'b1);
      end

      if (gnt_wr_c) begin
         state_d    = WRITE;
         addr_d     = wr_sel_c.addr;
         wdata_d    = wr_sel_c.data;
         wr_ack_d   = {src_c == SRC_WR1, src_c == SRC_WR0};
         rr_ptr_d   = (src_c == SRC_WR0);
         rd_burst_d = '0;
      end

      if (!wr_pend_c) rd_burst_d = '0;

      ce_n_d  = !((state_d == READ) || (state_d == WRITE));
      oe_n_d  = (state_d != READ);
      we_n_d  = !((state_d == WRITE) && (cnt_d != CNT_LAST));
      bl_n_d  = ce_n_d;
      dq_oe_d = (state_d == WRITE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rr_ptr_q   <= 1'b0;
         rd_burst_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
         rd_gnt_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         wr_ack_q   <= 2'b00;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         bl_n_q     <= 1'b1;
         dq_oe_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         rd_burst_q <= rd_burst_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_data_q  <= rd_data_d;
         rd_gnt_q   <= rd_gnt_d;
         rd_valid_q <= rd_valid_d;
         wr_ack_q   <= wr_ack_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         we_n_q     <= we_n_d;
         bl_n_q     <= bl_n_d;
         dq_oe_q    <= dq_oe_d;
      end
   end

   assign SRAM_DQ   = dq_oe_q ? wdata_q : {SRAM_DW{1'bz}};
   assign SRAM_ADDR = addr_q;
   assign SRAM_CE_N = ce_n_q;
   assign SRAM_OE_N = oe_n_q;
   assign SRAM_WE_N = we_n_q;
   assign SRAM_UB_N = bl_n_q;
   assign SRAM_LB_N = bl_n_q;
   assign rd_gnt    = rd_gnt_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign wr_ack    = wr_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM on the pins.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   typedef struct packed {
      logic [1:0]         kind;   // 0 read, 1 writer 0, 2 writer 1
      logic [SRAM_AW-1:0] addr;
      logic [SRAM_DW-1:0] data;
   } gnt_exp_t;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               rd_req;
   logic [SRAM_AW-1:0] rd_addr;
   logic               rd_gnt, rd_valid;
   logic [SRAM_DW-1:0] rd_data;
   logic [1:0]         wr_req, wr_ack;
   logic [SRAM_AW-1:0] wr_addr0, wr_addr1, sram_addr;
   logic [SRAM_DW-1:0] wr_data0, wr_data1;
   logic               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
   wire  [SRAM_DW-1:0] sram_dq;

   sram_arbiter #(.ACCESS_CYCLES(2), .MAX_RD_BURST(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
      .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ack(wr_ack),
      .SRAM_ADDR(sram_addr), .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n),
      .SRAM_WE_N(sram_we_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
      .SRAM_DQ(sram_dq)
   );

   always #10 clk = ~clk;

   // SRAM model (low 10 address bits); probe_en drives a marker to prove DQ is released.
   logic [SRAM_DW-1:0] mem [0:1023];
   logic               probe_en;
   wire                model_rd = !sram_ce_n && !sram_oe_n && sram_we_n;
   assign sram_dq = probe_en ? 16'hA5C3 : (model_rd ? mem[sram_addr[9:0]] : 16'hzzzz);

   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) mem[sram_addr[9:0]] <= sram_dq;
   end

   int checks = 0;
   int errors = 0;
   gnt_exp_t           exp_gnt_q[$];
   logic [SRAM_DW-1:0] exp_rd_q[$];
   gnt_exp_t           mon_e;
   logic [1:0]         mon_kind;
   logic [SRAM_DW-1:0] mon_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_rd(input logic [SRAM_AW-1:0] a, input logic [SRAM_DW-1:0] d);
      exp_gnt_q.push_back('{kind: 2'd0, addr: a, data: 16'h0});
      exp_rd_q.push_back(d);
   endtask

   task automatic exp_wr(input logic [1:0] k, input logic [SRAM_AW-1:0] a,
                         input logic [SRAM_DW-1:0] d);
      exp_gnt_q.push_back('{kind: k, addr: a, data: d});
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a grant/ack or read data.
   always @(negedge clk) begin
      if (rd_gnt || (wr_ack != 2'b00)) begin
         if (rd_gnt && (wr_ack != 2'b00)) mon_kind = 2'd3;
         else if (rd_gnt)                 mon_kind = 2'd0;
         else if (wr_ack == 2'b01)        mon_kind = 2'd1;
         else if (wr_ack == 2'b10)        mon_kind = 2'd2;
         else                             mon_kind = 2'd3;
         if (exp_gnt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: rd_gnt=%0b wr_ack=%b with none expected", rd_gnt, wr_ack);
         end else begin
            mon_e = exp_gnt_q.pop_front();
            check("grant_kind", 32'(mon_kind), 32'(mon_e.kind));
            check("grant_addr", 32'(sram_addr), 32'(mon_e.addr));
            if (mon_e.kind != 2'd0) check("write_dq", 32'(sram_dq), 32'(mon_e.data));
         end
      end
      if (rd_valid) begin
         if (exp_rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd_valid: rd_data=0x%0h with none expected", rd_data);
         end else begin
            mon_d = exp_rd_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(mon_d));
         end
      end
   end

   // Waits for an event (0 rd_gnt, 1 wr_ack, 2 rd_valid); also counts CE_N-high and WE_N-low cycles.
   task automatic wait_for(input int which, output int n, output int ce_hi, output int we_lo);
      logic hit;
      n = 0; ce_hi = 0; we_lo = 0; hit = 1'b0;
      while (!hit && n < 64) begin
         @(negedge clk);
         n++;
         if (sram_ce_n)  ce_hi++;
         if (!sram_we_n) we_lo++;
         case (which)
            0:       hit = rd_gnt;
            1:       hit = |wr_ack;
            default: hit = rd_valid;
         endcase
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL wait_timeout: event %0d not seen within %0d cycles", which, n);
      end
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_strobes"}, 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
      check({tag, "_addr"}, 32'(sram_addr), 32'h0);
      check({tag, "_dq_released"}, 32'(sram_dq), 32'hA5C3);
      check({tag, "_pulses"}, 32'({rd_gnt, rd_valid, wr_ack}), 32'h0);
      check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, n2, ce_hi, we_lo, ce2, we2, ce_sum, rd_cnt, rd_at_wr;

      for (int i = 0; i < 1024; i++) mem[i] = 16'hDEAD;
      mem[10'h064] = 16'h001F;
      reset_n = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 2'b00;
      wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0; probe_en = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      probe_en = 1'b1;
      @(negedge clk);
      check_reset_pins("reset");
      probe_en = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single read
      rd_addr = 20'h00064; rd_req = 1'b1;
      exp_rd(20'h00064, 16'h001F);
      wait_for(0, n, ce_hi, we_lo);
      rd_req = 1'b0;
      check("rd_gnt_latency", 32'(n), 32'd1);
      wait_for(2, n2, ce_hi, we_lo);
      check("rd_valid_latency", 32'(n + n2), 32'd3);
      repeat (2) @(negedge clk);

      // Writer fairness, both writers held
      wr_addr0 = 20'h00100; wr_data0 = 16'hA1A1;
      wr_addr1 = 20'h00204; wr_data1 = 16'hB2B2;
      wr_req = 2'b11;
      exp_wr(2'd1, 20'h00100, 16'hA1A1);
      exp_wr(2'd2, 20'h00204, 16'hB2B2);
      exp_wr(2'd1, 20'h00308, 16'hC3C3);
      exp_wr(2'd2, 20'h0040C, 16'hD4D4);
      ce_sum = 0;
      for (int k = 0; k < 4; k++) begin
         wait_for(1, n, ce_hi, we_lo);
         if (k == 0) check("wr_ack_latency", 32'(n), 32'd1);
         else begin
            check("wr_back_to_back", 32'(n), 32'd2);
            ce_sum += ce_hi;
         end
         if (wr_ack[0]) begin wr_addr0 = 20'h00308; wr_data0 = 16'hC3C3; end
         if (wr_ack[1]) begin wr_addr1 = 20'h0040C; wr_data1 = 16'hD4D4; end
         if (k == 3) wr_req = 2'b00;
      end
      @(negedge clk);
      if (sram_ce_n) ce_sum++;
      check("fair_ce_low_continuous", 32'(ce_sum), 32'd0);
      @(negedge clk);
      check("mem_100", 32'(mem[10'h100]), 32'hA1A1);
      check("mem_204", 32'(mem[10'h204]), 32'hB2B2);
      check("mem_308", 32'(mem[10'h308]), 32'hC3C3);
      check("mem_40C", 32'(mem[10'h00C]), 32'hD4D4);
      repeat (2) @(negedge clk);

      // Single write then read-back through a TURN cycle
      mem[10'h0C8] = 16'hFFFF;
      wr_addr0 = 20'h1F4C8; wr_data0 = 16'h0000; wr_req = 2'b01;
      exp_wr(2'd1, 20'h1F4C8, 16'h0000);
      wait_for(1, n, ce_hi, we_lo);
      wr_req = 2'b00;
      rd_addr = 20'h1F4C8; rd_req = 1'b1;
      exp_rd(20'h1F4C8, 16'h0000);
      wait_for(0, n2, ce2, we2);
      rd_req = 1'b0;
      check("write_ack_latency", 32'(n), 32'd1);
      check("write_we_low_cycles", 32'(we_lo + we2), 32'd1);
      check("turn_gap", 32'(n2), 32'd3);
      check("turn_ce_high_cycles", 32'(ce2), 32'd1);
      wait_for(2, n, ce_hi, we_lo);
      repeat (2) @(negedge clk);

      // Read priority over a simultaneous write
      rd_addr = 20'h00064; rd_req = 1'b1;
      wr_addr0 = 20'h00510; wr_data0 = 16'h5A5A; wr_req = 2'b01;
      exp_rd(20'h00064, 16'h001F);
      exp_wr(2'd1, 20'h00510, 16'h5A5A);
      wait_for(0, n, ce_hi, we_lo);
      rd_req = 1'b0;
      wait_for(1, n2, ce_hi, we_lo);
      wr_req = 2'b00;
      check("prio_write_after_read", 32'(n2), 32'd2);
      repeat (3) @(negedge clk);
      check("mem_510", 32'(mem[10'h110]), 32'h5A5A);

      // Starvation limit: constant reads against a held writer 1
      rd_addr = 20'h00064; rd_req = 1'b1;
      wr_addr1 = 20'h00618; wr_data1 = 16'h7E7E; wr_req = 2'b10;
      for (int k = 0; k < 8; k++) exp_rd(20'h00064, 16'h001F);
      exp_wr(2'd2, 20'h00618, 16'h7E7E);
      exp_rd(20'h00064, 16'h001F);
      exp_rd(20'h00064, 16'h001F);
      rd_cnt = 0; rd_at_wr = -1; n = 0;
      while (rd_cnt < 10 && n < 200) begin
         @(negedge clk);
         n++;
         if (rd_gnt) rd_cnt++;
         if (wr_ack[1]) begin rd_at_wr = rd_cnt; wr_req = 2'b00; end
         if (rd_cnt == 10) rd_req = 1'b0;
      end
      rd_req = 1'b0; wr_req = 2'b00;
      check("reads_before_write", 32'(rd_at_wr), 32'd8);
      check("reads_total", 32'(rd_cnt), 32'd10);
      repeat (6) @(negedge clk);

      // Reset during the first WRITE cycle
      wr_addr0 = 20'h00720; wr_data0 = 16'h1234; wr_req = 2'b01;
      exp_wr(2'd1, 20'h00720, 16'h1234);
      wait_for(1, n, ce_hi, we_lo);
      reset_n = 1'b0; wr_req = 2'b00;
      @(posedge clk);
      #1 probe_en = 1'b1;
      @(negedge clk);
      check_reset_pins("midwrite");
      probe_en = 1'b0;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_ce_n", 32'(sram_ce_n), 32'd1);

      check("grant_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
      check("read_queue_drained", 32'(exp_rd_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences and shares the single-port 1M×16 board SRAM between three requesters: the VGA line prefetcher (reads), the sprite/program draw engine (writes), and the background clear engine (writes). It sits between these clients and the SRAM pins. It owns every SRAM control strobe, the address bus and the tri-state DQ bus, so no other block drives the SRAM. Reads take priority. A burst limiter prevents write starvation, and the two writers are served round-robin.

## Interface
- `ACCESS_CYCLES`, default 2: cycles per SRAM word access (≥2).
- `MAX_RD_BURST`, default 8: maximum consecutive read grants while any write is pending.
- `clk` in 1: 50 MHz system clock. All logic on rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `rd_req` in 1: VGA read request. Held with `rd_addr` until `rd_gnt`.
- `rd_addr` in 20: read word address.
- `rd_gnt` out 1: one-cycle pulse; `rd_addr` captured.
- `rd_valid` out 1: one-cycle pulse; `rd_data` valid.
- `rd_data` out 16: read word. Holds its value until the next `rd_valid`.
- `wr_req[1:0]` in 2: write requests; index 0 = draw, 1 = clear. Each held until its own ack.
- `wr_addr0`, `wr_addr1` in 20: write addresses.
- `wr_data0`, `wr_data1` in 16: write data.
- `wr_ack[1:0]` out 2: one-hot one-cycle pulse; that writer's address and data captured.
- `SRAM_ADDR` out 20; `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each, all active-low.
- `SRAM_DQ` inout 16: driven only during write states, otherwise Z.

## Operation
- FSM states: IDLE, READ, WRITE, TURN.
- Arbitration is evaluated in IDLE and in the last cycle of READ/WRITE, so back-to-back accesses are possible.
- Arbitration order:
  - If `rd_req` is set and (no write pending or `rd_burst < MAX_RD_BURST`): grant the read.
  - Else if any `wr_req` is set: grant the writer selected round-robin. `rr_ptr` is the preferred index; it flips to the other index after each write grant.
  - Else go to IDLE.
- `rd_burst` behaviour:
  - Increments on each read grant while a write is pending, saturating at `MAX_RD_BURST`.
  - Clears on any write grant, and whenever no write is pending.
- READ: `SRAM_CE_N`=0, `SRAM_OE_N`=0, `SRAM_WE_N`=1, `SRAM_UB_N`/`SRAM_LB_N`=0, address = captured `rd_addr`. `SRAM_DQ` is sampled into `rd_data` at the end of the last access cycle.
- WRITE:
  - `SRAM_CE_N`=0, `SRAM_OE_N`=1, `SRAM_DQ` driven with captured data.
  - `SRAM_WE_N`=0 in all but the last access cycle. `SRAM_WE_N`=1 in the last cycle, so data is held past the WE rising edge.
- TURN: one cycle inserted whenever a READ is granted directly after a WRITE. DQ is Z and all strobes are inactive. Read after read, write after write and write after read need no TURN.
- Width rules:
  - Address and data are passed through unmodified; there is no address arithmetic.
  - The access counter is `$clog2(ACCESS_CYCLES)` bits and wraps to 0 at `ACCESS_CYCLES-1`.
- Simultaneous requests: a read and both writers arriving in the same cycle → read is granted first, then writers alternate starting from `rr_ptr`.
- Reset (including mid-access), applied on the next edge:
  - FSM → IDLE; `rr_ptr`, `rd_burst` and the access counter → 0.
  - All strobes → 1, `SRAM_ADDR` → 0, DQ → Z.
  - `rd_gnt`, `rd_valid`, `wr_ack`, `rd_data` → 0.
  - An in-flight access is abandoned and produces no `rd_valid` or ack.

## Timing
- Request sampled at edge t (FSM in IDLE) → `rd_gnt` or `wr_ack` is high during cycle t+1, which is also the first access cycle.
- The access occupies cycles t+1 … t+`ACCESS_CYCLES`. Read `rd_valid` is high during cycle t+`ACCESS_CYCLES`+1.
- Read latency from request to data is `ACCESS_CYCLES`+1 cycles.
- Sustained throughput for same-direction or write-after-read traffic: one word per `ACCESS_CYCLES`. A read following a write costs `ACCESS_CYCLES`+1 cycles (TURN).
- All outputs are registered; there are no combinational paths from inputs to SRAM pins.

## Structure
- Package `sram_arb_pkg`:
  - `SRAM_AW`=20, `SRAM_DW`=16.
  - `typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} sram_arb_state_t`.
  - `typedef enum logic [1:0] {SRC_NONE, SRC_RD, SRC_WR0, SRC_WR1} sram_src_t`.
- Sub-module `sram_arb_select`: a combinational picker taking `rd_req`, `wr_req`, `rr_ptr` and `rd_burst` saturation, and outputting `sram_src_t`. It is unit-testable on its own.
- The top holds the FSM, access counter, capture registers and tri-state driver.

## Test plan
- Single read: preload addr 0x00064 = 0x001F; `rd_req` pulse with `rd_addr`=0x00064 → `rd_gnt` next cycle, `rd_valid` 3 cycles after the request edge, `rd_data`=0x001F.
- Single write then read-back:
  - `wr_req[0]`, addr 0x1F4C8, data 0x0000 → `wr_ack`=2'b01, `SRAM_WE_N` low for exactly 1 cycle.
  - The following read to 0x1F4C8 shows one TURN cycle and returns 0x0000.
- Writer fairness: `wr_req`=2'b11 held for 4 grants, no read → acks in order 01, 10, 01, 10; `SRAM_CE_N` low continuously.
- Starvation limit: `rd_req` held constantly with `wr_req[1]` held → exactly 8 read grants, 1 write grant, then reads resume.
- Read priority: `rd_req` and `wr_req`=2'b01 asserted in the same cycle → read granted first, write granted on the next arbitration.
- Reset mid-write: assert `reset_n`=0 during the first WRITE cycle → next edge shows all strobes 1, DQ Z, no `wr_ack` re-pulse. After release, an idle bus shows `SRAM_CE_N`=1.
